operand_skewer: RTL

- Sits directly upstream of systolic_array.
- Accepts one unskewed K-beat stream of A rows and B columns from the unified buffer over a valid/ready handshake.
- Delays lane i by i cycles to form the diagonal wavefront, pads with zeros for the flush, and generates input/weight first/last markers and compute_enable.
- Pulses done when the last operand has reached PE[N-1][N-1].

---
 rtl/npu_pkg.sv | 24 ++
 rtl/skew_delay_line.sv | 35 +++
 rtl/operand_skewer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// Shared NPU types and sizing for the operand skewer.
// Array size and operand width come from ARRAY_SIZE / DATA_WIDTH defines,
// defaulted here when the build does not supply them.
`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package npu_pkg;
  localparam int NPU_N  = `ARRAY_SIZE;
  localparam int NPU_DW = `DATA_WIDTH;

  // Zero beats needed after the last real beat to drain the diagonal.
  localparam int SKEW_FLUSH_CYCLES = 2*(`ARRAY_SIZE-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } skewer_state_t;
endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated shift register of DEPTH stages; DEPTH==0 is a wire.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = &{1'b0, clk, rst_n, en};
      assign q = d;
    end else begin : g_shift
      logic [DEPTH-1:0][WIDTH-1:0] stg;

      // Shift one stage per advance; stalls freeze the whole line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg <= '0;
        end else if (en) begin
          stg[0] <= d;
          for (int j = 1; j < DEPTH; j++) stg[j] <= stg[j-1];
        end
      end

      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/operand_skewer.sv
// operand_skewer: turns an unskewed K-beat A/B stream into the diagonal
// wavefront for the systolic array. Lane i is delayed i advances, the tail
// is flushed with 2(N-1) zero beats, and first/last markers plus
// compute_enable are generated alongside the data.
// Optional: TINYNPU_SKEW_STALL_CNT_EN enables the FEED stall counter.
module operand_skewer
  import npu_pkg::*;
#(
  parameter int N  = NPU_N,
  parameter int DW = NPU_DW,
  parameter int KW = 16
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_vec,
  input  logic [N*DW-1:0] b_vec,
  output logic [N*DW-1:0] input_data,
  output logic [N*DW-1:0] weight_data,
  output logic            input_first,
  output logic            weight_first,
  output logic            input_last,
  output logic            weight_last,
  output logic            compute_enable,
  output logic            busy,
  output logic            done,
  output logic [31:0]     stall_cycles
);

  localparam int FLUSH_CYC = 2*(N-1);
  localparam int FCW       = $clog2(2*N);

  skewer_state_t        state, state_nxt;
  logic [KW-1:0]        k_lat, beat_cnt;
  logic [FCW-1:0]       flush_cnt;
  logic                 adv, last_beat, flush_end, start_acc;
  logic                 first0, last0;
  logic [0:0]           last_dl;
  logic [N-1:0][DW-1:0] a_in, b_in, a_dl, b_dl;

  assign start_acc = (state == IDLE) && start;
  assign last_beat = (beat_cnt == k_lat - KW'(1));
  assign flush_end = (flush_cnt == FCW'(FLUSH_CYC-1));
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, handshake and advance strobe.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (k_len == '0) ? DONE : FEED;
      end
      FEED: begin
        in_ready = 1'b1;
        adv      = in_valid;
        if (in_valid && last_beat) state_nxt = (FLUSH_CYC == 0) ? DONE : FLUSH;
      end
      FLUSH: begin
        adv = 1'b1;
        if (flush_end) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched K plus beat and flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else if (start_acc) begin
      k_lat     <= k_len;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == FEED && in_valid) beat_cnt  <= beat_cnt + KW'(1);
      if (state == FLUSH)            flush_cnt <= flush_cnt + FCW'(1);
    end
  end

  // Real data only while feeding; flush pushes zeros down every lane.
  assign a_in = (state == FEED) ? a_vec : '0;
  assign b_in = (state == FEED) ? b_vec : '0;

  // Lane-0 marker sources; last is skewed to lane N-1 with the data.
  assign first0 = (state == FEED) && (beat_cnt == '0);
  assign last0  = (state == FEED) && last_beat;

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      skew_delay_line #(.DEPTH(i), .WIDTH(DW)) u_a (
        .clk(clk), .rst_n(rst_n), .en(adv), .d(a_in[i]), .q(a_dl[i])
      );
      skew_delay_line #(.DEPTH(i), .WIDTH(DW)) u_b (
        .clk(clk), .rst_n(rst_n), .en(adv), .d(b_in[i]), .q(b_dl[i])
      );
    end
  endgenerate

  skew_delay_line #(.DEPTH(N-1), .WIDTH(1)) u_last (
    .clk(clk), .rst_n(rst_n), .en(adv), .d(last0), .q(last_dl)
  );

  // Output register: data updates only on advance, strobes are pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_data     <= '0;
      weight_data    <= '0;
      input_first    <= 1'b0;
      weight_first   <= 1'b0;
      input_last     <= 1'b0;
      weight_last    <= 1'b0;
      compute_enable <= 1'b0;
      done           <= 1'b0;
    end else begin
      compute_enable <= adv;
      input_first    <= adv & first0;
      weight_first   <= adv & first0;
      input_last     <= adv & last_dl[0];
      weight_last    <= adv & last_dl[0];
      done           <= (state == DONE);
      if (adv) begin
        input_data  <= a_dl;
        weight_data <= b_dl;
      end
    end
  end

`ifdef TINYNPU_SKEW_STALL_CNT_EN
  logic [31:0] stall_q;

  // Count FEED cycles starved of input; saturating, cleared per job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            stall_q <= '0;
    else if (start_acc)                                    stall_q <= '0;
    else if (state == FEED && !in_valid && stall_q != '1)  stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
